// File: rtl/shift_reg_burst_if.sv
// +--------------------------------------------------------------------------+
// | shift_reg_burst_if : command/status bundle for the burst shift register  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface shift_reg_burst_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [2:0]       mode;
  logic             serial_in;
  logic [WIDTH-1:0] shiftreg;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output load, data, start, count, mode, serial_in,
    input  shiftreg, serial_out, busy, done
  );

  modport slave (
    input  load, data, start, count, mode, serial_in,
    output shiftreg, serial_out, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/shift_reg_burst.sv
// +--------------------------------------------------------------------------+
// | shift_reg_burst : parametrised load/shift register with counted bursts.  |
// | Optional rotate modes enabled by defining SHIFT_REG_ROTATE_EN.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_reg_burst_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] c_mode_lsl = 3'b001;
  localparam logic [2:0] c_mode_lsr = 3'b010;
  localparam logic [2:0] c_mode_asr = 3'b011;
`ifdef SHIFT_REG_ROTATE_EN
  localparam logic [2:0] c_mode_rol = 3'b100;
  localparam logic [2:0] c_mode_ror = 3'b101;
`endif

  state_t             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic               so_q, so_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   w_shift_val;
  logic               w_shift_out;

  // Next register value and exit bit for one step of the latched mode.
  always_comb begin
    w_shift_val = sr_q;
    w_shift_out = so_q;
    case (mode_q)
      c_mode_lsl: begin
        w_shift_val = {sr_q[WIDTH-2:0], bus.serial_in};
        w_shift_out = sr_q[WIDTH-1];
      end
      c_mode_lsr: begin
        w_shift_val = {bus.serial_in, sr_q[WIDTH-1:1]};
        w_shift_out = sr_q[0];
      end
      c_mode_asr: begin
        w_shift_val = {sr_q[WIDTH-1], sr_q[WIDTH-1:1]};
        w_shift_out = sr_q[0];
      end
`ifdef SHIFT_REG_ROTATE_EN
      c_mode_rol: begin
        w_shift_val = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        w_shift_out = sr_q[WIDTH-1];
      end
      c_mode_ror: begin
        w_shift_val = {sr_q[0], sr_q[WIDTH-1:1]};
        w_shift_out = sr_q[0];
      end
`endif
      default: begin
        w_shift_val = sr_q;
        w_shift_out = so_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    sr_d    = sr_q;
    so_d    = so_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          sr_d = bus.data;
        end else if (bus.start) begin
          if (bus.count != '0) begin
            mode_d  = bus.mode;
            rem_d   = bus.count;
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        sr_d  = w_shift_val;
        so_d  = w_shift_out;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'b000;
      rem_q   <= '0;
      sr_q    <= '0;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      sr_q    <= sr_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.shiftreg   = sr_q;
  assign bus.serial_out = so_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_burst.sv
// +--------------------------------------------------------------------------+
// | tb_shift_reg_burst : directed vector bench for shift_reg_burst           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_shift_reg_burst;

  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic       st;
    logic [3:0] cnt;
    logic [2:0] md;
    logic       si;
    logic [7:0] e_sr;
    logic       e_so;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  shift_reg_burst_if #(.WIDTH(8), .CNT_W(4)) bus ();

  shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [7:0] d, input logic st,
                       input logic [3:0] cnt, input logic [2:0] md, input logic si);
    bus.load = ld; bus.data = d; bus.start = st;
    bus.count = cnt; bus.mode = md; bus.serial_in = si;
  endtask

  function automatic vec_t mk(input logic ld, input logic [7:0] d, input logic st,
                              input logic [3:0] cnt, input logic [2:0] md, input logic si,
                              input logic [7:0] e_sr, input logic e_so,
                              input logic e_busy, input logic e_done);
    vec_t v;
    v.ld = ld; v.d = d; v.st = st; v.cnt = cnt; v.md = md; v.si = si;
    v.e_sr = e_sr; v.e_so = e_so; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  vec_t vecs[24];

  initial begin
    logic [7:0] rsr;
    logic       rso;
    int         n_done;
    int         cyc;
`ifdef SHIFT_REG_ROTATE_EN
    rsr = 8'hC0; rso = 1'b1;
`else
    rsr = 8'h81; rso = 1'b0;
`endif
    //           ld d      st cnt md si   sr     so   busy done
    vecs[0]  = mk(1, 8'hA5, 0, 0, 0, 0,   8'hA5, 0,   0, 0);
    vecs[1]  = mk(0, 8'h00, 1, 3, 1, 0,   8'hA5, 0,   1, 0);
    vecs[2]  = mk(0, 8'h00, 0, 0, 0, 0,   8'h4A, 1,   1, 0);
    vecs[3]  = mk(0, 8'h00, 0, 0, 0, 0,   8'h94, 0,   1, 0);
    vecs[4]  = mk(0, 8'h00, 0, 0, 0, 0,   8'h28, 1,   0, 1);
    vecs[5]  = mk(0, 8'h00, 0, 0, 0, 0,   8'h28, 1,   0, 0);
    vecs[6]  = mk(1, 8'h90, 0, 0, 0, 0,   8'h90, 1,   0, 0);
    vecs[7]  = mk(0, 8'h00, 1, 2, 3, 0,   8'h90, 1,   1, 0);
    vecs[8]  = mk(1, 8'hFF, 1, 5, 1, 0,   8'hC8, 0,   1, 0);
    vecs[9]  = mk(1, 8'hFF, 0, 0, 0, 0,   8'hE4, 0,   0, 1);
    vecs[10] = mk(0, 8'h00, 0, 0, 0, 0,   8'hE4, 0,   0, 0);
    vecs[11] = mk(1, 8'h81, 0, 0, 0, 0,   8'h81, 0,   0, 0);
    vecs[12] = mk(0, 8'h00, 1, 1, 5, 0,   8'h81, 0,   1, 0);
    vecs[13] = mk(0, 8'h00, 0, 0, 0, 0,   rsr,   rso, 0, 1);
    vecs[14] = mk(0, 8'h00, 0, 0, 0, 0,   rsr,   rso, 0, 0);
    vecs[15] = mk(0, 8'h00, 1, 0, 1, 0,   rsr,   rso, 0, 1);
    vecs[16] = mk(0, 8'h00, 0, 0, 0, 0,   rsr,   rso, 0, 0);
    vecs[17] = mk(1, 8'h3C, 1, 4, 1, 0,   8'h3C, rso, 0, 0);
    vecs[18] = mk(0, 8'h00, 0, 0, 0, 0,   8'h3C, rso, 0, 0);
    vecs[19] = mk(0, 8'h00, 1, 1, 2, 1,   8'h3C, rso, 1, 0);
    vecs[20] = mk(0, 8'h00, 1, 1, 1, 1,   8'h9E, 0,   0, 1);
    vecs[21] = mk(0, 8'h00, 1, 1, 1, 0,   8'h9E, 0,   1, 0);
    vecs[22] = mk(0, 8'h00, 0, 0, 0, 0,   8'h3C, 1,   0, 1);
    vecs[23] = mk(0, 8'h00, 0, 0, 0, 0,   8'h3C, 1,   0, 0);

    drive(0, 8'h00, 0, 0, 0, 0);
    // Asynchronous reset asserted between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("rst sr",   32'(bus.shiftreg),   32'h00);
    chk("rst so",   32'(bus.serial_out), 32'h0);
    chk("rst busy", 32'(bus.busy),       32'h0);
    chk("rst done", 32'(bus.done),       32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ld, vecs[i].d, vecs[i].st, vecs[i].cnt, vecs[i].md, vecs[i].si);
      tick();
      chk($sformatf("row%0d sr", i),   32'(bus.shiftreg),   32'(vecs[i].e_sr));
      chk($sformatf("row%0d so", i),   32'(bus.serial_out), 32'(vecs[i].e_so));
      chk($sformatf("row%0d busy", i), 32'(bus.busy),       32'(vecs[i].e_busy));
      chk($sformatf("row%0d done", i), 32'(bus.done),       32'(vecs[i].e_done));
    end
    drive(0, 8'h00, 0, 0, 0, 0);

    // Clear, then abort a long burst with a mid-cycle reset after 5 shifts.
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 8'h00, 1, 15, 2, 1);
    tick();
    drive(0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("abort pre sr",   32'(bus.shiftreg), 32'hF8);
    chk("abort pre busy", 32'(bus.busy),     32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort sr",   32'(bus.shiftreg),   32'h00);
    chk("abort so",   32'(bus.serial_out), 32'h0);
    chk("abort busy", 32'(bus.busy),       32'h0);
    chk("abort done", 32'(bus.done),       32'h0);
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
    end
    chk("abort no done", 32'(n_done), 32'd0);

    // Restarted burst runs to completion.
    drive(0, 8'h00, 1, 15, 2, 1);
    tick();
    drive(0, 8'h00, 0, 0, 0, 1);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("restart shifts", 32'(cyc),            32'd15);
    chk("restart sr",     32'(bus.shiftreg),   32'hFF);
    chk("restart so",     32'(bus.serial_out), 32'h1);
    chk("restart busy",   32'(bus.busy),       32'h0);
    tick();
    chk("restart done clr", 32'(bus.done), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
